mem_bus_unit: RTL

- Data-memory stage that sits directly downstream of the accumulator CPU's MAR/MBR registers.
- Replaces the CPU-internal memory array and the store-to-test-register stub with a real read/write memory, accessed over a four-phase Req/Ack handshake.
- Inserts a configurable number of wait states so the CPU state machine is exercised against slow memory.
- Flags out-of-range addresses, because MAR is 8 bits but the array holds only DEPTH words.

---
 rtl/mem_bus_unit.sv | 87 ++++++++
 1 files changed

// File: rtl/mem_bus_unit.sv
// mem_bus_unit: Req/Ack data memory with configurable wait states and out-of-range flagging
module mem_bus_unit #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req,
    input  logic              We,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic [DATA_W-1:0] RData,
    output logic              Ack,
    output logic              Busy,
    output logic              Err,
    input  logic [ADDR_W-1:0] Dbg_Addr,
    output logic [DATA_W-1:0] Dbg_Data
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

    state_t state, state_nxt;
    logic [3:0] cnt;
    logic we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic in_range, dbg_in_range;

    assign in_range     = {1'b0, addr_q} < DEPTH_L;
    assign dbg_in_range = {1'b0, Dbg_Addr} < DEPTH_L;
    assign Busy         = state != IDLE;
    assign Dbg_Data     = dbg_in_range ? mem[Dbg_Addr[IDX_W-1:0]] : '0;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = Req ? ((WAIT_CYCLES == 0) ? ACCESS : WAIT) : IDLE;
            WAIT:    state_nxt = (cnt == 4'd1) ? ACCESS : WAIT;
            ACCESS:  state_nxt = DONE;
            default: state_nxt = Req ? DONE : IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            RData   <= '0;
            Ack     <= 1'b0;
            Err     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Req) begin
                    we_q    <= We;
                    addr_q  <= Addr;
                    wdata_q <= WData;
                    Err     <= 1'b0;
                    cnt     <= 4'(WAIT_CYCLES);
                end
                WAIT: cnt <= cnt - 4'd1;
                ACCESS: begin
                    RData <= in_range ? (we_q ? wdata_q : mem[addr_q[IDX_W-1:0]]) : '0;
                    Err   <= !in_range;
                    Ack   <= 1'b1;
                end
                default: if (!Req) Ack <= 1'b0;
            endcase
        end
    end

    // No reset on the array: contents survive Rst_n, and a reset before ACCESS cancels the write
    always_ff @(posedge Clk) begin
        if (state == ACCESS && we_q && in_range) mem[addr_q[IDX_W-1:0]] <= wdata_q;
    end
endmodule
